// File: rtl/pll_lock_sequencer_pkg.sv
// rtl/pll_lock_sequencer_pkg.sv - state encodings and default timing for the PLL lock sequencer
package pll_lock_sequencer_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int DEF_PLL_RESET_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT       = 12000;
  localparam int DEF_LOCK_STABLE_CYCLES = 1200;
  localparam int DEF_MAX_RETRIES        = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with asynchronous active-low reset to 0
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - drives PLL RESETB, qualifies LOCK and gates the system reset
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int PLL_RESET_CYCLES   = DEF_PLL_RESET_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max3(PLL_RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES) + 1);
  localparam int ATT_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s is the first of the stable cycles.
  localparam logic [CNT_W-1:0] STABLE_LAST  =
    CNT_W'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ATT_W-1:0] attempt_q, attempt_d;
  logic [7:0]       loss_d;
  logic             lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clock_in),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      attempt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      attempt_q <= attempt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    attempt_d = attempt_q;
    loss_d    = lock_loss_cnt;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RESET_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (int'(attempt_q) + 1 >= MAX_RETRIES) begin
            state_d = FAULT;
          end else begin
            attempt_d = attempt_q + ATT_W'(1);
            state_d   = RESET_PLL;
          end
        end
      end
      STABILIZE: begin
        if (!lock_s)                   state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q;
        // Lock loss wins over a coincident restart so the loss is always recorded.
        if (!lock_s) begin
          state_d   = RESET_PLL;
          attempt_d = '0;
          loss_d    = (lock_loss_cnt == 8'hFF) ? lock_loss_cnt : lock_loss_cnt + 8'd1;
        end else if (restart_req) begin
          state_d   = RESET_PLL;
          attempt_d = '0;
        end
      end
      FAULT: begin
        cnt_d = cnt_q;
        if (restart_req) begin
          state_d   = RESET_PLL;
          attempt_d = '0;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      pll_resetb    <= 1'b0;
      sys_reset_n   <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
      retry_count   <= 2'd0;
      lock_loss_cnt <= 8'd0;
    end else begin
      pll_resetb    <= (state_d == WAIT_LOCK) || (state_d == STABILIZE);
      sys_reset_n   <= (state_d == RUN);
      ready         <= (state_d == RUN);
      fault         <= (state_d == FAULT);
      retry_count   <= (int'(attempt_d) > 3) ? 2'd3 : 2'(attempt_d);
      lock_loss_cnt <= loss_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;
  import pll_lock_sequencer_pkg::*;

  localparam int T_RESET   = 4;
  localparam int T_TIMEOUT = 50;
  localparam int T_STABLE  = 10;
  localparam int T_RETRIES = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  pll_lock_sequencer #(
    .PLL_RESET_CYCLES   (T_RESET),
    .LOCK_TIMEOUT       (T_TIMEOUT),
    .LOCK_STABLE_CYCLES (T_STABLE),
    .MAX_RETRIES        (T_RETRIES)
  ) dut (
    .clock_in      (clk),
    .reset_n       (rst_n),
    .pll_locked    (pll_locked),
    .restart_req   (restart_req),
    .pll_resetb    (pll_resetb),
    .sys_reset_n   (sys_reset_n),
    .ready         (ready),
    .fault         (fault),
    .retry_count   (retry_count),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    restart_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string tag, output int cycles);
    cycles = 0;
    while (!ready && cycles < 200) begin
      tick(1);
      cycles++;
    end
    check(tag, ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resetb"}, pll_resetb, 0);
    check({tag, "_sysrst"}, sys_reset_n, 0);
    check({tag, "_ready"},  ready, 0);
    check({tag, "_fault"},  fault, 0);
    check({tag, "_retry"},  retry_count, 0);
    check({tag, "_loss"},   lock_loss_cnt, 0);
  endtask

  initial begin
    int cyc;
    int rises;
    logic prev;

    // 1. Clean lock
    rst_n = 1'b0; pll_locked = 1'b0; restart_req = 1'b0;
    #3;
    check_reset_outputs("rst");
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("t1_resetb_low_c3", pll_resetb, 0);
    tick(1);
    check("t1_resetb_high_c4", pll_resetb, 1);
    tick(16);
    pll_locked = 1'b1;
    tick(11);
    check("t1_ready_c11", ready, 0);
    tick(1);
    check("t1_ready_c12", ready, 1);
    check("t1_sysrst_c12", sys_reset_n, 1);
    check("t1_retry", retry_count, 0);

    // 2. Glitch during STABILIZE
    do_reset();
    tick(4);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(5);
    check("t2_ready_after_glitch", ready, 0);
    check("t2_resetb_after_glitch", pll_resetb, 1);
    check("t2_retry_after_glitch", retry_count, 0);
    pll_locked = 1'b1;
    tick(11);
    check("t2_ready_c11", ready, 0);
    tick(1);
    check("t2_ready_c12", ready, 1);
    check("t2_retry_final", retry_count, 0);

    // 3. Never lock: three attempts of 4 + 50 cycles, then FAULT
    do_reset();
    rises = 0;
    prev  = pll_resetb;
    for (int i = 1; i <= 162; i++) begin
      tick(1);
      if (pll_resetb && !prev) rises++;
      prev = pll_resetb;
      if (i == 54)  check("t3_retry1", retry_count, 1);
      if (i == 108) check("t3_retry2", retry_count, 2);
      if (i == 161) check("t3_fault_c161", fault, 0);
      if (i == 162) check("t3_fault_c162", fault, 1);
    end
    check("t3_attempts", rises, 3);
    tick(20);
    check("t3_fault_held", fault, 1);
    check("t3_resetb_held", pll_resetb, 0);
    check("t3_sysrst_held", sys_reset_n, 0);
    check("t3_retry_at_fault", retry_count, 2);
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    check("t3_fault_cleared", fault, 0);
    check("t3_retry_cleared", retry_count, 0);
    tick(4);
    check("t3_restart_resetb", pll_resetb, 1);

    // 4. Lock loss in RUN
    do_reset();
    pll_locked = 1'b1;
    wait_ready("t4_first_run", cyc);
    pll_locked = 1'b0;
    tick(2);
    check("t4_ready_edge2", ready, 1);
    tick(1);
    check("t4_ready_edge3", ready, 0);
    check("t4_sysrst_edge3", sys_reset_n, 0);
    check("t4_loss_cnt", lock_loss_cnt, 1);
    pll_locked = 1'b1;
    tick(3);
    check("t4_resetb_low", pll_resetb, 0);
    tick(1);
    check("t4_resetb_high", pll_resetb, 1);
    wait_ready("t4_relock", cyc);
    check("t4_loss_after_relock", lock_loss_cnt, 1);

    // 5. Async reset mid-STABILIZE (lock_loss_cnt is 1 going in)
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    tick(8);
    check("t5_in_stabilize", pll_resetb, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t5");
    #1 rst_n = 1'b1;
    tick(3);
    check("t5_resetb_low_c3", pll_resetb, 0);
    tick(1);
    check("t5_resetb_high_c4", pll_resetb, 1);
    wait_ready("t5_relock", cyc);

    // 6. Restart request coinciding with lock loss in RUN
    pll_locked = 1'b0;
    tick(2);
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    check("t6_loss_cnt", lock_loss_cnt, 1);
    check("t6_ready", ready, 0);
    check("t6_resetb", pll_resetb, 0);
    tick(4);
    check("t6_loss_once", lock_loss_cnt, 1);
    check("t6_wait_lock", pll_resetb, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
